bcd_to_bin_seq: RTL

//   Multi-cycle signed BCD -> two's-complement binary decoder (reverse double-dabble).

---
 rtl/bcd_to_bin_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// Multi-cycle signed BCD to two's-complement binary decoder (reverse double-dabble).
// Accepts {sign, BCD digits} and returns an (N+1)-bit two's-complement value plus an
// error flag for invalid digits or out-of-range magnitudes. Valid/ready on both sides.
`timescale 1ns/1ps
module bcd_to_bin_seq #(
  parameter  int N      = 7,
  localparam int DIGITS = N / 3 + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*DIGITS:0] bcd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N:0]        binary_out,
  output logic              err
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BW);
  localparam logic [BW-1:0] MAX_POS = BW'((2 ** N) - 1);
  localparam logic [BW-1:0] MAX_NEG = BW'(2 ** N);

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   bcd_reg;
  logic [BW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            sign_reg;
  logic            bad_digit;

  logic [2*BW-1:0] shifted;
  logic [BW-1:0]   bcd_nx;
  logic [BW-1:0]   acc_nx;
  logic            in_bad;
  logic [N:0]      fix_bin;
  logic            fix_err;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  // NOTE: the default is assigned first so no path leaves state_nx unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid)                   state_nx = SHIFT;
      SHIFT: if (cnt == CW'(BW - 1))         state_nx = FIX;
      FIX:                                   state_nx = DONE;
      DONE:  if (out_ready)                  state_nx = IDLE;
      default:                               state_nx = IDLE;
    endcase
  end

  // One reverse double-dabble step: shift {bcd, acc} right, then correct digits >= 8.
  always_comb begin
    shifted = {bcd_reg, acc} >> 1;
    bcd_nx  = shifted[2*BW-1:BW];
    acc_nx  = shifted[BW-1:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_nx[4*i +: 4] >= 4'd8) bcd_nx[4*i +: 4] = bcd_nx[4*i +: 4] - 4'd3;
    end
  end

  // Flag any incoming digit above 9.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // Range check, saturation and sign application on the finished magnitude.
  always_comb begin
    fix_bin = acc[N:0];
    fix_err = 1'b0;
    if (bad_digit) begin
      fix_bin = '0;
      fix_err = 1'b1;
    end else if (!sign_reg && acc > MAX_POS) begin
      fix_bin = {1'b0, {N{1'b1}}};
      fix_err = 1'b1;
    end else if (sign_reg && acc > MAX_NEG) begin
      fix_bin = {1'b1, {N{1'b0}}};
      fix_err = 1'b1;
    end else if (sign_reg) begin
      fix_bin = (~acc[N:0]) + 1'b1;
    end
  end

  // Datapath: capture on accept, shift in SHIFT, publish result in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_reg    <= '0;
      acc        <= '0;
      cnt        <= '0;
      sign_reg   <= 1'b0;
      bad_digit  <= 1'b0;
      binary_out <= '0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          bcd_reg   <= bcd_in[BW-1:0];
          sign_reg  <= bcd_in[BW];
          acc       <= '0;
          cnt       <= '0;
          bad_digit <= in_bad;
        end
        SHIFT: begin
          bcd_reg <= bcd_nx;
          acc     <= acc_nx;
          cnt     <= cnt + 1'b1;
        end
        FIX: begin
          binary_out <= fix_bin;
          err        <= fix_err;
        end
        default: ;
      endcase
    end
  end

endmodule
